// File: rtl/mod_4051_pkg.sv
// Shared constants and state encoding for the mod-4051 inverse engine.
package mod_4051_pkg;

   localparam int          RES_W = 12;
   localparam logic [11:0] MOD_P = 12'd4051;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mod_4051_halve.sv
// Combinational x/2 mod 4051 for a residue x in [0, 4050].
// Odd x: (x+P)/2 = floor(x/2) + (P+1)/2, so no 13-bit sum is needed.
module mod_4051_halve
   import mod_4051_pkg::*;
(
   input  logic [11:0] x_i,
   output logic [11:0] half_o
);

   localparam logic [11:0] HALF_UP = (MOD_P + 12'd1) >> 1;

   assign half_o = (x_i >> 1) + (x_i[0] ? HALF_UP : 12'd0);

endmodule

// File: rtl/mod_4051_inv.sv
// Sequential modular inverse mod 4051, one binary extended-Euclid step per cycle.
// Invariants: x1*a == u and x2*a == v (mod P); result held in DONE until out_ready.
module mod_4051_inv
   import mod_4051_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_a,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_inv,
   output logic        out_err
);

   state_e      state_q;
   logic [11:0] u_q, v_q, x1_q, x2_q;
   logic [11:0] u_d, v_d, x1_d, x2_d;
   logic [11:0] inv_q;
   logic        err_q, vld_q;

   logic [11:0] a_red;
   logic [11:0] x1_half, x2_half;
   logic signed [12:0] d1_s, d2_s;
   logic [11:0] x1_sub, x2_sub;

   // 4095 < 2*P, so a single conditional subtract fully reduces the operand
   assign a_red = (in_a >= MOD_P) ? (in_a - MOD_P) : in_a;

   mod_4051_halve u_halve_x1 (.x_i(x1_q), .half_o(x1_half));
   mod_4051_halve u_halve_x2 (.x_i(x2_q), .half_o(x2_half));

   assign d1_s   = $signed({1'b0, x1_q}) - $signed({1'b0, x2_q});
   assign d2_s   = $signed({1'b0, x2_q}) - $signed({1'b0, x1_q});
   assign x1_sub = d1_s[12] ? (d1_s[11:0] + MOD_P) : d1_s[11:0];
   assign x2_sub = d2_s[12] ? (d2_s[11:0] + MOD_P) : d2_s[11:0];

   always_comb begin
      u_d  = u_q;
      v_d  = v_q;
      x1_d = x1_q;
      x2_d = x2_q;
      if (!u_q[0]) begin
         u_d  = u_q >> 1;
         x1_d = x1_half;
      end else if (!v_q[0]) begin
         v_d  = v_q >> 1;
         x2_d = x2_half;
      end else if (u_q >= v_q) begin
         u_d  = u_q - v_q;
         x1_d = x1_sub;
      end else begin
         v_d  = v_q - u_q;
         x2_d = x2_sub;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         u_q     <= 12'd0;
         v_q     <= 12'd0;
         x1_q    <= 12'd0;
         x2_q    <= 12'd0;
         inv_q   <= 12'd0;
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  if (a_red == 12'd0) begin
                     inv_q   <= 12'd0;
                     err_q   <= 1'b1;
                     vld_q   <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     u_q     <= a_red;
                     v_q     <= MOD_P;
                     x1_q    <= 12'd1;
                     x2_q    <= 12'd0;
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (u_q == 12'd1) begin
                  inv_q   <= x1_q;
                  err_q   <= 1'b0;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else if (v_q == 12'd1) begin
                  inv_q   <= x2_q;
                  err_q   <= 1'b0;
                  vld_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  u_q  <= u_d;
                  v_q  <= v_d;
                  x1_q <= x1_d;
                  x2_q <= x2_d;
               end
            end
            DONE: begin
               if (out_ready) begin
                  vld_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = vld_q;
   assign out_inv   = inv_q;
   assign out_err   = err_q;

endmodule
